// File: rtl/instruction_decode_stage.sv
// IF/ID pipeline register and decoder: drives register_file read ports from the held
// instruction, registers the EX control word, and inserts one-cycle load-use bubbles.
module instruction_decode_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_IDX_WIDTH = 5,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [DATA_WIDTH-1:0]    instruction_i,
    input  logic                     instruction_valid_i,
    input  logic                     flush_i,
    output logic [REG_IDX_WIDTH-1:0] register_1_read_addr_o,
    output logic [REG_IDX_WIDTH-1:0] register_2_read_addr_o,
    output logic                     register_read_o,
    output logic                     fetch_stall_o,
    output logic                     ex_valid_o,
    output logic [REG_IDX_WIDTH-1:0] ex_dest_addr_o,
    output logic [DATA_WIDTH-1:0]    ex_imm_o,
    output logic [5:0]               ex_opcode_o,
    output logic [5:0]               ex_funct_o,
    output logic                     ex_reg_write_o,
    output logic                     ex_mem_read_o,
    output logic                     ex_mem_write_o,
    output logic                     ex_branch_o,
    output logic                     illegal_pulse_o,
    output logic [CNT_WIDTH-1:0]     illegal_count_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t                   state_r;
    logic [DATA_WIDTH-1:0]    ifid_instr_r;
    logic                     ifid_valid_s;
    logic [5:0]               op_s;
    logic [5:0]               funct_s;
    logic [REG_IDX_WIDTH-1:0] rs_s;
    logic [REG_IDX_WIDTH-1:0] rt_s;
    logic [REG_IDX_WIDTH-1:0] rd_s;
    logic [15:0]              imm16_s;
    logic                     uses_rt_s;
    logic                     hazard_s;
    logic                     issue_s;

    logic                     dec_legal_s;
    logic [REG_IDX_WIDTH-1:0] dec_dest_s;
    logic [DATA_WIDTH-1:0]    dec_imm_s;
    logic                     dec_write_s;
    logic                     dec_mem_read_s;
    logic                     dec_mem_write_s;
    logic                     dec_branch_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        if (value == {CNT_WIDTH{1'b1}}) begin
            sat_inc = value;
        end else begin
            sat_inc = value + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    assign ifid_valid_s = (state_r != IDLE);
    assign op_s         = ifid_instr_r[31:26];
    assign rs_s         = ifid_instr_r[25:21];
    assign rt_s         = ifid_instr_r[20:16];
    assign rd_s         = ifid_instr_r[15:11];
    assign imm16_s      = ifid_instr_r[15:0];
    assign funct_s      = ifid_instr_r[5:0];

    // rt is only a true source operand for R-type, stores and compare-branches
    assign uses_rt_s = (op_s == 6'h00) | (op_s == 6'h2B) | (op_s == 6'h04) | (op_s == 6'h05);
    assign hazard_s  = ifid_valid_s & ex_valid_o & ex_mem_read_o
                     & (ex_dest_addr_o != {REG_IDX_WIDTH{1'b0}})
                     & ((ex_dest_addr_o == rs_s) | (uses_rt_s & (ex_dest_addr_o == rt_s)));
    assign issue_s   = ifid_valid_s & ~hazard_s & ~flush_i;

    assign fetch_stall_o   = hazard_s & ~flush_i;
    assign register_read_o = issue_s;

    // Read addresses are zeroed while IF/ID is empty
    always_comb begin
        if (ifid_valid_s) begin
            register_1_read_addr_o = rs_s;
            register_2_read_addr_o = rt_s;
        end else begin
            register_1_read_addr_o = {REG_IDX_WIDTH{1'b0}};
            register_2_read_addr_o = {REG_IDX_WIDTH{1'b0}};
        end
    end

    // Opcode decode of the IF/ID instruction into the EX control word
    always_comb begin
        dec_legal_s     = 1'b1;
        dec_dest_s      = {REG_IDX_WIDTH{1'b0}};
        dec_imm_s       = {{(DATA_WIDTH-16){imm16_s[15]}}, imm16_s};
        dec_write_s     = 1'b0;
        dec_mem_read_s  = 1'b0;
        dec_mem_write_s = 1'b0;
        dec_branch_s    = 1'b0;
        case (op_s)
            6'h00: begin
                dec_dest_s  = rd_s;
                dec_write_s = (funct_s != 6'h08);
            end
            6'h08, 6'h09, 6'h0A, 6'h0B: begin
                dec_dest_s  = rt_s;
                dec_write_s = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dec_dest_s  = rt_s;
                dec_write_s = 1'b1;
                dec_imm_s   = {{(DATA_WIDTH-16){1'b0}}, imm16_s};
            end
            6'h0F: begin
                dec_dest_s  = rt_s;
                dec_write_s = 1'b1;
                dec_imm_s   = {imm16_s, {(DATA_WIDTH-16){1'b0}}};
            end
            6'h23: begin
                dec_dest_s     = rt_s;
                dec_write_s    = 1'b1;
                dec_mem_read_s = 1'b1;
            end
            6'h2B: dec_mem_write_s = 1'b1;
            6'h04, 6'h05: dec_branch_s = 1'b1;
            default: begin
                dec_legal_s = 1'b0;
                dec_imm_s   = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // IF/ID register and occupancy state; flush beats hazard beats load
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r      <= IDLE;
            ifid_instr_r <= {DATA_WIDTH{1'b0}};
        end else if (flush_i) begin
            state_r      <= IDLE;
            ifid_instr_r <= ifid_instr_r;
        end else if (hazard_s) begin
            state_r      <= STALL;
            ifid_instr_r <= ifid_instr_r;
        end else begin
            state_r      <= instruction_valid_i ? RUN : IDLE;
            ifid_instr_r <= instruction_i;
        end
    end

    // EX control word, illegal-opcode pulse and saturating counter
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            ex_valid_o      <= 1'b0;
            ex_dest_addr_o  <= {REG_IDX_WIDTH{1'b0}};
            ex_imm_o        <= {DATA_WIDTH{1'b0}};
            ex_opcode_o     <= 6'h00;
            ex_funct_o      <= 6'h00;
            ex_reg_write_o  <= 1'b0;
            ex_mem_read_o   <= 1'b0;
            ex_mem_write_o  <= 1'b0;
            ex_branch_o     <= 1'b0;
            illegal_pulse_o <= 1'b0;
            illegal_count_o <= {CNT_WIDTH{1'b0}};
        end else begin
            if (issue_s & dec_legal_s) begin
                ex_valid_o     <= 1'b1;
                ex_dest_addr_o <= dec_dest_s;
                ex_imm_o       <= dec_imm_s;
                ex_opcode_o    <= op_s;
                ex_funct_o     <= funct_s;
                ex_reg_write_o <= dec_write_s & (dec_dest_s != {REG_IDX_WIDTH{1'b0}});
                ex_mem_read_o  <= dec_mem_read_s;
                ex_mem_write_o <= dec_mem_write_s;
                ex_branch_o    <= dec_branch_s;
            end else begin
                ex_valid_o     <= 1'b0;
                ex_dest_addr_o <= {REG_IDX_WIDTH{1'b0}};
                ex_imm_o       <= {DATA_WIDTH{1'b0}};
                ex_opcode_o    <= 6'h00;
                ex_funct_o     <= 6'h00;
                ex_reg_write_o <= 1'b0;
                ex_mem_read_o  <= 1'b0;
                ex_mem_write_o <= 1'b0;
                ex_branch_o    <= 1'b0;
            end
            illegal_pulse_o <= issue_s & ~dec_legal_s;
            illegal_count_o <= (issue_s & ~dec_legal_s) ? sat_inc(illegal_count_o) : illegal_count_o;
        end
    end

endmodule
